// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter that shares one data mux among NUM_REQ burst-capable
//   requesters and presents a single valid/ready output port. A grant is held
//   until the burst ends, either on the requester's last beat or after
//   MAX_BURST beats, whichever comes first. At least one idle cycle separates
//   two grants.
//
// Ports
//   clk        in   1                    clock, rising edge
//   rst_n      in   1                    asynchronous reset, active low
//   req_valid  in   NUM_REQ              per-requester beat valid
//   req_last   in   NUM_REQ              per-requester last beat of burst
//   req_data   in   NUM_REQ*DATA_WIDTH   packed data, requester i at [(i+1)*DW-1:i*DW]
//   req_ready  out  NUM_REQ              per-requester beat accepted
//   out_valid  out  1                    output beat valid
//   out_ready  in   1                    downstream ready
//   out_data   out  DATA_WIDTH           data of the granted requester
//   out_last   out  1                    burst end (requester last or forced)
//   out_src    out  IDX_W                index of the granted requester
//   busy       out  1                    high while a grant is held
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// parametric_mux
//   Selects one DATA_WIDTH word out of NUM_IN packed words.
// Ports
//   i_data  in   NUM_IN*DATA_WIDTH  packed input words
//   i_sel   in   SEL_W              word index
//   o_data  out  DATA_WIDTH         selected word
// -----------------------------------------------------------------------------
module parametric_mux #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 4,
    parameter int SEL_W      = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]             i_sel,
    output logic [DATA_WIDTH-1:0]        o_data
);

    // Word select; NUM_IN is a power of two so every i_sel value is a valid word.
    always_comb begin
        o_data = i_data[int'(i_sel)*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

module rr_mux_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [$clog2(NUM_REQ)-1:0]    out_src,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_any_req;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cand;
    logic               w_burst_end;
    logic               w_xfer;
    logic               w_forced_last;

    assign w_any_req     = |req_valid;
    assign w_forced_last = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    // Burst end as seen by the grant logic; only meaningful in GRANT.
    assign w_burst_end   = req_last[r_grant_idx] | w_forced_last;
    assign w_xfer        = (r_state == ST_GRANT) & req_valid[r_grant_idx] & out_ready;

    // Round-robin search: scan from the highest priority distance downwards so
    // the last hit, which wins, is the requester closest to r_rr_ptr.
    always_comb begin
        w_winner = r_rr_ptr;
        w_cand   = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand   = r_rr_ptr + IDX_W'(k);
            w_winner = req_valid[w_cand] ? w_cand : w_winner;
        end
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_xfer && w_burst_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered grant; outputs follow rst_n at once
    // because they depend only on asynchronously reset state.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_GRANT: begin
                busy                   = 1'b1;
                out_valid              = req_valid[r_grant_idx];
                out_last               = w_burst_end;
                req_ready[r_grant_idx] = out_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign out_src = r_grant_idx;

    // Data path: the mux always follows the last grant, also while idle.
    parametric_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_REQ),
        .SEL_W      (IDX_W)
    ) u_mux (
        .i_data (req_data),
        .i_sel  (r_grant_idx),
        .o_data (out_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant index, beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_idx <= w_winner;
                        r_beat_cnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        // Next search starts just after the requester that
                        // finished; IDX_W-bit arithmetic wraps NUM_REQ-1 -> 0.
                        if (w_burst_end) begin
                            r_rr_ptr <= r_grant_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
